// File: rtl/ex_stage_pkg.sv
// Shared widths, opcode/mem_type encodings and bus layouts for the MIPS execute stage.
// Imported by the interface, the divider and the stage top.
package ex_stage_pkg;

   localparam int ID_TO_EX_WD  = 145;
   localparam int EX_TO_MEM_WD = 80;
   localparam int EX_TO_ID_WD  = 38;
   localparam int STALL_W      = 6;

   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,  ALU_SUB   = 5'd1,  ALU_SLT  = 5'd2,  ALU_SLTU = 5'd3,
      ALU_AND   = 5'd4,  ALU_OR    = 5'd5,  ALU_XOR  = 5'd6,  ALU_NOR  = 5'd7,
      ALU_SLL   = 5'd8,  ALU_SRL   = 5'd9,  ALU_SRA  = 5'd10, ALU_LUI  = 5'd11,
      ALU_PASS  = 5'd12, ALU_MULT  = 5'd13, ALU_MULTU = 5'd14, ALU_DIV = 5'd15,
      ALU_DIVU  = 5'd16, ALU_MFHI  = 5'd17, ALU_MFLO = 5'd18, ALU_MTHI = 5'd19,
      ALU_MTLO  = 5'd20
   } alu_op_e;

   localparam logic [3:0] MEM_W  = 4'b1111;
   localparam logic [3:0] MEM_B  = 4'b0001;
   localparam logic [3:0] MEM_BU = 4'b0010;
   localparam logic [3:0] MEM_H  = 4'b0011;
   localparam logic [3:0] MEM_HU = 4'b0100;

   typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

   typedef struct packed {
      logic [31:0] pc;
      alu_op_e     alu_op;
      logic [31:0] alu_src1;
      logic [31:0] alu_src2;
      logic [31:0] rt_data;
      logic        mem_en;
      logic        mem_we;
      logic [3:0]  mem_type;
      logic        rf_we;
      logic [4:0]  rf_waddr;
   } id_to_ex_t;

   function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX/MEM-facing signal bundle of the execute stage; master is the EX stage itself.
interface ex_stage_if;
   import ex_stage_pkg::*;

   logic [STALL_W-1:0]      stall;
   logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [EX_TO_ID_WD-1:0]  ex_to_id;
   logic                    ex_is_load;
   logic                    stallreq_for_ex;
   logic                    data_sram_en;
   logic [3:0]              data_sram_wen;
   logic [31:0]             data_sram_addr;
   logic [31:0]             data_sram_wdata;

   modport master (
      input  stall, id_to_ex_bus,
      output ex_to_mem_bus, ex_to_id, ex_is_load, stallreq_for_ex,
             data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
   );

   modport slave (
      output stall, id_to_ex_bus,
      input  ex_to_mem_bus, ex_to_id, ex_is_load, stallreq_for_ex,
             data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
   );

endinterface

// File: rtl/ex_stage_div_iter.sv
// Iterative 32-step restoring divider on operand magnitudes; signs are applied on the outputs.
// Result is held in DONE until ack, which the owner ties to the pipeline advancing.
module div_iter
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ack,
   output logic        busy,
   output logic        done,
   output logic [31:0] quo,
   output logic [31:0] rem
);

   div_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic [32:0] trial;
   logic [32:0] diff;
   logic        ge;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      // Partial remainder shifted left with the next dividend bit brought in.
      trial   = {rem_q, quo_q[31]};
      diff    = trial - {1'b0, dvs_q};
      ge      = (trial >= {1'b0, dvs_q});
      case (state_q)
         DIV_IDLE: begin
            if (start) begin
               state_d = DIV_RUN;
               cnt_d   = 5'd0;
               rem_d   = 32'd0;
               quo_d   = neg_if(signed_op & a[31], a);
               dvs_d   = neg_if(signed_op & b[31], b);
               qneg_d  = signed_op & (a[31] ^ b[31]);
               rneg_d  = signed_op & a[31];
            end
         end
         DIV_RUN: begin
            rem_d = ge ? diff[31:0] : trial[31:0];
            quo_d = {quo_q[30:0], ge};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = DIV_DONE;
         end
         DIV_DONE: begin
            if (ack) state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
   end

   assign busy = ((state_q == DIV_IDLE) && start) || (state_q == DIV_RUN);
   assign done = (state_q == DIV_DONE);
   assign quo  = neg_if(qneg_q, quo_q);
   assign rem  = neg_if(rneg_q, rem_q);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, HI/LO with multiply and iterative divide,
// data-SRAM request generation and the EX->MEM / EX->ID forwarding buses.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   ex_stage_if.master bus
);

   logic [ID_TO_EX_WD-1:0] id_to_ex_r_q, id_to_ex_r_d;
   logic [31:0]            hi_q, hi_d;
   logic [31:0]            lo_q, lo_d;
   id_to_ex_t              id;
   logic [31:0]            ex_result;
   logic [4:0]             shamt;
   logic [63:0]            prod_s, prod_u;
   logic                   advance;
   logic                   div_start, div_busy, div_done;
   logic [31:0]            div_quo, div_rem;
   logic [3:0]             wen;
   logic [31:0]            wdata;

   // A stalled ID with EX free to move injects a bubble; a stalled EX holds.
   always_comb begin
      id_to_ex_r_d = id_to_ex_r_q;
      if (bus.stall[2] == NOSTOP)      id_to_ex_r_d = bus.id_to_ex_bus;
      else if (bus.stall[3] == NOSTOP) id_to_ex_r_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) id_to_ex_r_q <= '0;
      else     id_to_ex_r_q <= id_to_ex_r_d;
   end

   assign id      = id_to_ex_t'(id_to_ex_r_q);
   assign shamt   = id.alu_src1[4:0];
   assign advance = (bus.stall[2] == NOSTOP);
   assign prod_s  = {{32{id.alu_src1[31]}}, id.alu_src1} * {{32{id.alu_src2[31]}}, id.alu_src2};
   assign prod_u  = {32'd0, id.alu_src1} * {32'd0, id.alu_src2};

   always_comb begin
      ex_result = 32'd0;
      case (id.alu_op)
         ALU_ADD:  ex_result = id.alu_src1 + id.alu_src2;
         ALU_SUB:  ex_result = id.alu_src1 - id.alu_src2;
         ALU_SLT:  ex_result = {31'd0, $signed(id.alu_src1) < $signed(id.alu_src2)};
         ALU_SLTU: ex_result = {31'd0, id.alu_src1 < id.alu_src2};
         ALU_AND:  ex_result = id.alu_src1 & id.alu_src2;
         ALU_OR:   ex_result = id.alu_src1 | id.alu_src2;
         ALU_XOR:  ex_result = id.alu_src1 ^ id.alu_src2;
         ALU_NOR:  ex_result = ~(id.alu_src1 | id.alu_src2);
         ALU_SLL:  ex_result = id.alu_src2 << shamt;
         ALU_SRL:  ex_result = id.alu_src2 >> shamt;
         ALU_SRA:  ex_result = 32'($signed(id.alu_src2) >>> shamt);
         ALU_LUI:  ex_result = {id.alu_src2[15:0], 16'd0};
         ALU_PASS: ex_result = id.alu_src1;
         ALU_MFHI: ex_result = hi_q;
         ALU_MFLO: ex_result = lo_q;
         default:  ex_result = 32'd0;
      endcase
   end

   assign div_start = ((id.alu_op == ALU_DIV) || (id.alu_op == ALU_DIVU)) && (id.alu_src2 != 32'd0);

   div_iter u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .signed_op (id.alu_op == ALU_DIV),
      .a         (id.alu_src1),
      .b         (id.alu_src2),
      .ack       (advance),
      .busy      (div_busy),
      .done      (div_done),
      .quo       (div_quo),
      .rem       (div_rem)
   );

   // HI/LO only move on an edge where the instruction leaves EX, so each write happens once.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (advance) begin
         if (div_done) begin
            hi_d = div_rem;
            lo_d = div_quo;
         end else begin
            case (id.alu_op)
               ALU_MULT:  {hi_d, lo_d} = prod_s;
               ALU_MULTU: {hi_d, lo_d} = prod_u;
               ALU_MTHI:  hi_d = id.alu_src1;
               ALU_MTLO:  lo_d = id.alu_src1;
               default:   ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   always_comb begin
      wen   = 4'b0000;
      wdata = 32'd0;
      if (id.mem_en && id.mem_we) begin
         case (id.mem_type)
            MEM_W: begin
               wen   = 4'b1111;
               wdata = id.rt_data;
            end
            MEM_B: begin
               wen   = 4'b0001 << ex_result[1:0];
               wdata = {4{id.rt_data[7:0]}};
            end
            MEM_H: begin
               wen   = ex_result[1] ? 4'b1100 : 4'b0011;
               wdata = {2{id.rt_data[15:0]}};
            end
            default: wen = 4'b0000;
         endcase
      end
   end

   assign bus.ex_to_mem_bus   = {id.mem_type, id.pc, id.mem_en, wen, id.mem_en & ~id.mem_we,
                                 id.rf_we, id.rf_waddr, ex_result};
   assign bus.ex_to_id        = {id.rf_we, id.rf_waddr, ex_result};
   assign bus.ex_is_load      = id.mem_en & ~id.mem_we;
   assign bus.stallreq_for_ex = div_busy;
   assign bus.data_sram_en    = id.mem_en;
   assign bus.data_sram_wen   = wen;
   assign bus.data_sram_addr  = id.mem_en ? ex_result : 32'd0;
   assign bus.data_sram_wdata = wdata;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, SRAM requests, HI/LO, divider stall timing, bubbles and reset.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   vecs = 0;
   int   errs = 0;
   int   n;

   always #5 clk = ~clk;

   ex_stage_if bus_if ();

   ex_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [144:0] mk(input logic [31:0] pc, input logic [4:0] op,
                                       input logic [31:0] s1, input logic [31:0] s2,
                                       input logic [31:0] rt, input logic men, input logic mwe,
                                       input logic [3:0] mt, input logic rfwe, input logic [4:0] wa);
      return {pc, op, s1, s2, rt, men, mwe, mt, rfwe, wa};
   endfunction

   task automatic issue(input logic [144:0] v);
      bus_if.id_to_ex_bus = v;
      bus_if.stall        = 6'b000000;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                 = 1'b1;
      bus_if.stall        = 6'b000000;
      bus_if.id_to_ex_bus = mk(32'h100, ALU_ADD, 32'h5, 32'h6, 32'h0, 1'b1, 1'b1, MEM_W, 1'b1, 5'd2);
      tick();
      tick();
      chk("rst_ex_to_mem", bus_if.ex_to_mem_bus, 80'd0);
      chk("rst_ex_to_id", 80'(bus_if.ex_to_id), 80'd0);
      chk("rst_sram", {bus_if.data_sram_en, bus_if.data_sram_wen, bus_if.data_sram_addr}, 80'd0);
      chk("rst_stallreq", 80'(bus_if.stallreq_for_ex), 80'd0);
      chk("rst_hilo", {16'd0, dut.hi_q, dut.lo_q}, 80'd0);
      rst = 1'b0;

      issue(mk(32'h100, ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd3));
      chk("add_ovf_bus", bus_if.ex_to_mem_bus,
          {4'h0, 32'h100, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd3, 32'h80000000});
      chk("add_ovf_fwd", 80'(bus_if.ex_to_id), 80'({1'b1, 5'd3, 32'h80000000}));
      issue(mk(32'h104, ALU_SRA, 32'd4, 32'h80000000, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd4));
      chk("sra", 80'(bus_if.ex_to_id[31:0]), 80'hF8000000);
      issue(mk(32'h108, ALU_SUB, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd4));
      chk("sub", 80'(bus_if.ex_to_id[31:0]), 80'hFFFFFFFE);
      issue(mk(32'h10C, ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd4));
      chk("slt", 80'(bus_if.ex_to_id[31:0]), 80'd1);
      issue(mk(32'h110, ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd4));
      chk("sltu", 80'(bus_if.ex_to_id[31:0]), 80'd0);
      issue(mk(32'h114, ALU_NOR, 32'h0F0F0000, 32'h000000F0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd4));
      chk("nor", 80'(bus_if.ex_to_id[31:0]), 80'hF0F0FF0F);
      issue(mk(32'h118, ALU_LUI, 32'h0, 32'h00001234, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd4));
      chk("lui", 80'(bus_if.ex_to_id[31:0]), 80'h12340000);

      issue(mk(32'h200, ALU_ADD, 32'h1000, 32'd3, 32'h12345678, 1'b1, 1'b1, MEM_B, 1'b0, 5'd0));
      chk("sb_bus", bus_if.ex_to_mem_bus,
          {MEM_B, 32'h200, 1'b1, 4'b1000, 1'b0, 1'b0, 5'd0, 32'h00001003});
      chk("sb_sram", {bus_if.data_sram_en, bus_if.data_sram_wen, bus_if.data_sram_addr, bus_if.data_sram_wdata},
          80'({1'b1, 4'b1000, 32'h00001003, 32'h78787878}));
      chk("sb_isload", 80'(bus_if.ex_is_load), 80'd0);
      issue(mk(32'h204, ALU_ADD, 32'h2000, 32'd2, 32'hAABBCCDD, 1'b1, 1'b0, MEM_H, 1'b1, 5'd8));
      chk("lh_sram", {bus_if.data_sram_en, bus_if.data_sram_wen, bus_if.data_sram_addr},
          80'({1'b1, 4'b0000, 32'h00002002}));
      chk("lh_isload_sel", 80'({bus_if.ex_is_load, bus_if.ex_to_mem_bus[38]}), 80'b11);
      issue(mk(32'h208, ALU_ADD, 32'h2000, 32'd2, 32'hAABBCCDD, 1'b1, 1'b1, MEM_H, 1'b0, 5'd0));
      chk("sh_sram", {bus_if.data_sram_wen, bus_if.data_sram_wdata}, 80'({4'b1100, 32'hCCDDCCDD}));
      issue(mk(32'h20C, ALU_ADD, 32'h3000, 32'd0, 32'hDEADBEEF, 1'b1, 1'b1, MEM_W, 1'b0, 5'd0));
      chk("sw_sram", {bus_if.data_sram_wen, bus_if.data_sram_wdata}, 80'({4'b1111, 32'hDEADBEEF}));

      issue(mk(32'h300, ALU_MULT, 32'hFFFFFFFE, 32'd3, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0));
      chk("mult_res0", 80'(bus_if.ex_to_id[31:0]), 80'd0);
      issue(mk(32'h304, ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd9));
      chk("mult_hi", 80'(bus_if.ex_to_id[31:0]), 80'hFFFFFFFF);
      issue(mk(32'h308, ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd9));
      chk("mult_lo", 80'(bus_if.ex_to_id[31:0]), 80'hFFFFFFFA);
      issue(mk(32'h30C, ALU_MULTU, 32'hFFFFFFFF, 32'd2, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0));
      issue(mk(32'h310, ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd9));
      chk("multu_hi", 80'(bus_if.ex_to_id[31:0]), 80'h1);

      // DIV -7/2 with the stall vector following stallreq like the hazard unit would.
      issue(mk(32'h400, ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0));
      n = 0;
      while (bus_if.stallreq_for_ex && n < 60) begin
         n++;
         bus_if.stall = 6'b001111;
         tick();
      end
      chk("div_stall_cycles", 80'(n), 80'd33);
      chk("div_done_hilo_hold", {16'd0, dut.hi_q, dut.lo_q}, {16'd0, 32'h1, 32'hFFFFFFFE});
      tick();
      tick();
      chk("div_done_forced_stall", {15'd0, bus_if.stallreq_for_ex, dut.hi_q, dut.lo_q},
          {15'd0, 1'b0, 32'h1, 32'hFFFFFFFE});
      issue(mk(32'h404, ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd10));
      chk("div_mflo", 80'(bus_if.ex_to_id[31:0]), 80'hFFFFFFFD);
      issue(mk(32'h408, ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd11));
      chk("div_mfhi", 80'(bus_if.ex_to_id[31:0]), 80'hFFFFFFFF);

      issue(mk(32'h500, ALU_DIVU, 32'd5, 32'd0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0));
      chk("divz_nostall", 80'(bus_if.stallreq_for_ex), 80'd0);
      issue('0);
      chk("divz_hilo", {16'd0, dut.hi_q, dut.lo_q}, {16'd0, 32'hFFFFFFFF, 32'hFFFFFFFD});

      issue(mk(32'h600, ALU_ADD, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd4));
      chk("pre_bubble", 80'(bus_if.ex_to_id), 80'({1'b1, 5'd4, 32'd3}));
      bus_if.id_to_ex_bus = mk(32'h604, ALU_ADD, 32'd9, 32'd9, 32'h0, 1'b1, 1'b1, MEM_W, 1'b1, 5'd6);
      bus_if.stall        = 6'b000100;
      tick();
      chk("bubble_mem", bus_if.ex_to_mem_bus, 80'd0);
      chk("bubble_id", {41'd0, bus_if.ex_to_id, bus_if.data_sram_en}, 80'd0);
      issue(mk(32'h608, ALU_ADD, 32'd10, 32'd20, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd5));
      bus_if.id_to_ex_bus = mk(32'h60C, ALU_ADD, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd7);
      bus_if.stall        = 6'b001100;
      tick();
      chk("hold", 80'(bus_if.ex_to_id), 80'({1'b1, 5'd5, 32'd30}));
      issue(mk(32'h60C, ALU_ADD, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd7));
      chk("after_hold", 80'(bus_if.ex_to_id), 80'({1'b1, 5'd7, 32'd2}));

      issue(mk(32'h700, ALU_MTHI, 32'h11111111, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0));
      issue(mk(32'h704, ALU_MTLO, 32'h22222222, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0));
      issue(mk(32'h708, ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd12));
      chk("mthi", 80'(bus_if.ex_to_id[31:0]), 80'h11111111);
      issue(mk(32'h70C, ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd12));
      chk("mtlo", 80'(bus_if.ex_to_id[31:0]), 80'h22222222);

      issue(mk(32'h800, ALU_DIVU, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0));
      bus_if.stall = 6'b001111;
      repeat (11) tick();
      chk("run_stallreq", 80'(bus_if.stallreq_for_ex), 80'd1);
      rst = 1'b1;
      tick();
      chk("rst_mid_stallreq", 80'(bus_if.stallreq_for_ex), 80'd0);
      chk("rst_mid_hilo", {16'd0, dut.hi_q, dut.lo_q}, 80'd0);
      chk("rst_mid_buses", {bus_if.ex_to_mem_bus[41:0], bus_if.ex_to_id}, 80'd0);
      rst                 = 1'b0;
      bus_if.id_to_ex_bus = '0;
      bus_if.stall        = 6'b000000;
      tick();
      chk("post_rst_idle", {41'd0, bus_if.stallreq_for_ex, bus_if.ex_to_id}, 80'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, sitting between ID and MEM. It registers the ID-to-EX bus, computes the ALU result, and issues the data-SRAM request for loads and stores. It owns the HI/LO registers and an iterative divider that stalls the pipeline. It produces the 80-bit EX-to-MEM bus and the EX forwarding bus consumed by ID.

## Interface
Parameters: none. Widths come from `lib/defines.vh`.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  `StallBus` (6)  pipeline stall vector; Stop = 1
- id_to_ex_bus  in  `ID_TO_EX_WD` (145)  {pc[31:0], alu_op[4:0], alu_src1[31:0], alu_src2[31:0], rt_data[31:0], mem_en, mem_we, mem_type[3:0], rf_we, rf_waddr[4:0]}, MSB first
- ex_to_mem_bus  out  `EX_TO_MEM_WD` (80)  {mem_type[3:0], pc[31:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}
- ex_to_id  out  38  {rf_we, rf_waddr, ex_result} for forwarding
- ex_is_load  out  1  mem_en & ~mem_we, used by ID for load-use stall
- stallreq_for_ex  out  1  divider busy
- data_sram_en  out  1
- data_sram_wen  out  4
- data_sram_addr  out  32
- data_sram_wdata  out  32

## Operation
Input register `id_to_ex_r`:
- rst: clear to 0.
- Bubble: stall[2]=Stop and stall[3]=NoStop. Clear to 0.
- Load: stall[2]=NoStop. Load id_to_ex_bus.
- Otherwise hold.

ALU (`alu_op`):
- ADD, SUB: no overflow trap.
- SLT, SLTU.
- AND, OR, XOR, NOR.
- SLL, SRL, SRA: shift amount is src1[4:0], value is src2.
- LUI: {src2[15:0], 16'b0}.
- PASS: result = src1.
- MFHI, MFLO: result = HI or LO.
- MULT, MULTU, DIV, DIVU, MTHI, MTLO: result 0.

HI/LO:
- MULT, MULTU: single-cycle 64-bit product, {HI,LO} ← product.
- MTHI: HI ← src1. MTLO: LO ← src1.
- Every HI/LO write happens only on an edge where stall[2]=NoStop, so it occurs exactly once per instruction.

Memory request, driven when mem_en=1:
- Address: data_sram_en=1, data_sram_addr=ex_result.
- Loads: wen=0000.
- mem_type 1111 (word store): wen=1111, wdata=rt_data.
- mem_type 0001 (byte store): wen=0001<<addr[1:0], wdata={4{rt_data[7:0]}}.
- mem_type 0011 (half store): wen=addr[1]?1100:0011, wdata={2{rt_data[15:0]}}.
- Bus fields: data_ram_en=mem_en, data_ram_wen=wen, sel_rf_res=mem_en&~mem_we.
- Load mem_type codes pass through unchanged: 1111 lw, 0001 lb, 0010 lbu, 0011 lh, 0100 lhu.

Divider FSM (DIV signed, DIVU unsigned):
- IDLE: on DIV/DIVU with src2≠0, latch operands and go to RUN, counter=0.
- Divide by zero: no FSM entry, HI/LO unchanged, no stall.
- RUN: one restoring step per cycle on magnitudes. After 32 steps go to DONE.
- DONE: apply signs. Quotient is negated if operand signs differ; remainder takes the dividend's sign. Go to IDLE only when stall[2]=NoStop; HI←remainder and LO←quotient on that edge. Otherwise hold DONE.
- stallreq_for_ex=1 in IDLE-with-pending-div and in all RUN cycles; 0 in DONE.

## Timing
- Outputs are combinational from `id_to_ex_r`, HI/LO and FSM state. Latency: 1 cycle from the ID bus to the outputs.
- Reset: all outputs 0, HI=LO=0, FSM=IDLE, stallreq_for_ex=0.
- DIV occupancy: stall high for 33 cycles (issue cycle + 32 RUN), then DONE. The pipeline advances at the end of DONE, so the instruction spends 34 cycles in EX.
- A div followed immediately by MFLO sees the new LO: the write happens at the edge where MFLO enters EX.
- rst mid-division aborts the division: FSM goes to IDLE and HI/LO clear.
- A bubble forces an all-zero bus: no SRAM request and rf_we=0.

## Structure
- `lib/defines.vh` holds `ID_TO_EX_WD`, `EX_TO_MEM_WD`, `StallBus`, `Stop`/`NoStop`, the alu_op codes and the mem_type codes.
- alu_op codes: ADD 0, SUB 1, SLT 2, SLTU 3, AND 4, OR 5, XOR 6, NOR 7, SLL 8, SRL 9, SRA 10, LUI 11, PASS 12, MULT 13, MULTU 14, DIV 15, DIVU 16, MFHI 17, MFLO 18, MTHI 19, MTLO 20.
- Sub-module `div_iter`: FSM, counter and 64-bit remainder/quotient shift register.
  - Inputs: start, signed_op, a, b, ack.
  - Outputs: busy, done, quo, rem.

## Test plan
1. ADD 0x7FFFFFFF+1: ex_result=0x80000000, no trap. SRA shamt 4 of 0x80000000 gives 0xF8000000.
2. SB rt=0x12345678 at addr 0x1003: wen=1000, wdata=0x78787878, en=1, sel_rf_res=0. LH: wen=0000, ex_is_load=1.
3. DIV -7/2: stallreq high exactly 33 cycles, then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). A following MFLO yields −3.
4. DIVU by 0: no stall, HI/LO unchanged.
5. stall[2]=1, stall[3]=0 for one cycle: next outputs all zero. With stall[2]=stall[3]=1, the register holds. Forced stall in DONE: HI/LO are written once, on release.
6. Assert rst at RUN cycle 10: FSM goes to IDLE, stallreq=0, HI=LO=0, all buses 0.
